conv_result_collector: RTL and testbench



---
 rtl/conv_pkg.sv | 32 +++
 rtl/result_ram.sv | 26 ++
 rtl/conv_result_collector.sv | 144 ++++++++++++++
 tb/tb_conv_result_collector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result path: output geometry,
// a constant-friendly ceil(log2) helper and the collector FSM encoding.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  function automatic int out_size(input int data_size, input int kernel_size,
                                  input int stride);
    return (data_size - kernel_size) / stride + 1;
  endfunction

  function automatic int out_nb(input int data_size, input int kernel_size,
                                input int stride);
    int s;
    s = out_size(data_size, kernel_size, stride);
    return s * s;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_ram.sv
// Result buffer: one synchronous write port, one synchronous read port with
// read enable. The read register holds its value while re is low, which lets
// the drain pipeline stall without re-reading. The array has no reset.
module result_ram #(
  parameter int SUM_BW  = 16,
  parameter int DEPTH   = 784,
  parameter int ADDR_BW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [SUM_BW-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [SUM_BW-1:0]  rdata
);

  logic [SUM_BW-1:0] mem [DEPTH];

  // Write port and registered read port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_result_collector.sv
// Captures one frame of sparse convolution results into a raster-ordered
// buffer, then drains it as a dense valid/ready stream with a last marker.
// Drain path: RAM read register (p1) -> output register, each stage stalls
// independently so the stream stays gapless under back-pressure.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int SUM_BW      = 16,
  parameter int DATA_SIZE   = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int RELU        = 0,
  parameter int OUT_ADDR_BW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [SUM_BW-1:0] i_y,
  input  logic              i_valid,
  output logic [SUM_BW-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_rlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  localparam int OUT_NB = out_nb(DATA_SIZE, KERNEL_SIZE, STRIDE);
  localparam int RAM_AW = clog2(OUT_NB);

  localparam logic [OUT_ADDR_BW-1:0] WR_LAST = OUT_ADDR_BW'(OUT_NB - 1);
  localparam logic [OUT_ADDR_BW:0]   RD_END  = (OUT_ADDR_BW + 1)'(OUT_NB);
  localparam logic [OUT_ADDR_BW:0]   RD_LAST = (OUT_ADDR_BW + 1)'(OUT_NB - 1);

  // Optional rectification applied on the way into the buffer.
  function automatic logic signed [SUM_BW-1:0] relu_f(input logic signed [SUM_BW-1:0] x);
    if (RELU != 0 && x[SUM_BW-1]) return '0;
    return x;
  endfunction

  state_t                  state;
  logic [OUT_ADDR_BW-1:0]  wr_ptr;
  logic [OUT_ADDR_BW:0]    rd_ptr;
  logic                    vld_p1;
  logic [OUT_ADDR_BW:0]    idx_p1;
  logic [SUM_BW-1:0]       rdata_p1;
  logic signed [SUM_BW-1:0] wdata_p0;

  logic wr_en;
  logic hs;
  logic out_ready;
  logic p1_ready;
  logic rd_issue;

  assign wdata_p0  = relu_f(i_y);
  assign wr_en     = (state == ST_CAPTURE) && i_valid;
  assign hs        = o_rvalid && i_rready;
  assign out_ready = !o_rvalid || i_rready;
  assign p1_ready  = !vld_p1 || out_ready;
  assign rd_issue  = (state == ST_DRAIN) && (rd_ptr != RD_END) && p1_ready;

  result_ram #(
    .SUM_BW (SUM_BW),
    .DEPTH  (OUT_NB),
    .ADDR_BW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr[RAM_AW-1:0]),
    .wdata(wdata_p0),
    .re   (rd_issue),
    .raddr(rd_ptr[RAM_AW-1:0]),
    .rdata(rdata_p1)
  );

  // Frame FSM: pointers, busy/done/overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_CAPTURE;
            wr_ptr <= '0;
            o_ovf  <= 1'b0;
            o_busy <= 1'b1;
          end else if (i_valid) begin
            o_ovf <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (i_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == WR_LAST) begin
              state  <= ST_DRAIN;
              rd_ptr <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (i_valid) o_ovf <= 1'b1;
          if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
          if (hs && o_rlast) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1 -> output register: valid bits and the visible beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
      o_rdata  <= '0;
    end else begin
      if (p1_ready) vld_p1 <= rd_issue;
      if (out_ready) begin
        o_rvalid <= vld_p1;
        o_rlast  <= vld_p1 && (idx_p1 == RD_LAST);
        if (vld_p1) o_rdata <= rdata_p1;
      end
    end
  end

  // Stage p0 -> p1: buffer index travelling alongside the read data.
  always_ff @(posedge clk) begin
    if (rd_issue) idx_p1 <= rd_ptr;
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: two instances (RELU=0 and RELU=1) share
// one stimulus stream; a scenario table drives frames and a queue model
// predicts the drained beats.
module tb_conv_result_collector;

  localparam int SUM_BW = 16;
  localparam int NB     = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, i_start, i_valid, i_rready;
  logic        [SUM_BW-1:0] i_y;
  logic signed [SUM_BW-1:0] rdata [2];
  logic                     rvalid[2], rlast[2], busy[2], done[2], ovf[2];

  conv_result_collector #(
    .SUM_BW(SUM_BW), .DATA_SIZE(8), .KERNEL_SIZE(3), .STRIDE(1), .RELU(0), .OUT_ADDR_BW(6)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_y(i_y), .i_valid(i_valid),
    .o_rdata(rdata[0]), .o_rvalid(rvalid[0]), .i_rready(i_rready), .o_rlast(rlast[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_ovf(ovf[0])
  );

  conv_result_collector #(
    .SUM_BW(SUM_BW), .DATA_SIZE(8), .KERNEL_SIZE(3), .STRIDE(1), .RELU(1), .OUT_ADDR_BW(6)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_y(i_y), .i_valid(i_valid),
    .o_rdata(rdata[1]), .o_rvalid(rvalid[1]), .i_rready(i_rready), .o_rlast(rlast[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_ovf(ovf[1])
  );

  typedef struct {
    string name;
    int    base;
    bit    rand_data;
    int    gap_pct;
    int    rdy_pct;
    bit    stray_idle;
    bit    stray_drain;
    bit    mid_start;
    int    rst_at;
    bit    exp_ovf;
    bit    chk_lat;
  } scen_t;

  int checks = 0;
  int fails  = 0;
  int q0[$];
  int q1[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input scen_t s);
    int  beats[2];
    int  dones[2];
    bit  stall[2];
    int  pd[2];
    bit  pl[2];
    int  first_v, last_hs, v, e;
    bit  fin;
    q0.delete();
    q1.delete();
    beats = '{0, 0};
    dones = '{0, 0};
    stall = '{0, 0};
    pd = '{0, 0};
    pl = '{0, 0};
    first_v = -1;
    last_hs = -1;
    fin = 1'b0;

    if (s.stray_idle) begin
      i_valid = 1'b1;
      i_y = 16'h0123;
      tick();
      i_valid = 1'b0;
      for (int d = 0; d < 2; d++) chk({s.name, " ovf_idle"}, ovf[d], 1);
    end

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk({s.name, " busy_rise"}, busy[d], 1);
      chk({s.name, " ovf_clr"}, ovf[d], 0);
      chk({s.name, " done_low"}, done[d], 0);
    end

    for (int i = 0; i < NB; i++) begin
      while ($urandom_range(99) < s.gap_pct) tick();
      if (s.mid_start && i == 10) begin
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int d = 0; d < 2; d++) chk({s.name, " busy_midstart"}, busy[d], 1);
      end
      v = s.rand_data ? (int'($urandom_range(65535)) - 32768) : (s.base + i);
      i_y = v[SUM_BW-1:0];
      i_valid = 1'b1;
      q0.push_back(v);
      q1.push_back(v < 0 ? 0 : v);
      tick();
      i_valid = 1'b0;
    end

    for (int it = 0; it < 2000; it++) begin
      i_rready = ($urandom_range(99) < s.rdy_pct);
      i_valid  = s.stray_drain && ($urandom_range(3) == 0);
      i_y      = 16'(($urandom_range(65535)));
      for (int d = 0; d < 2; d++) begin
        if (stall[d]) begin
          chk({s.name, " stall_valid"}, rvalid[d], 1);
          chk({s.name, " stall_data"}, rdata[d], pd[d]);
          chk({s.name, " stall_last"}, rlast[d], pl[d]);
        end
        if (d == 0 && rvalid[d] && first_v < 0) first_v = it;
        if (done[d]) begin
          dones[d]++;
          chk({s.name, " done_busy"}, busy[d], 0);
          chk({s.name, " done_beats"}, beats[d], NB);
        end
        if (rvalid[d] && i_rready) begin
          if (d == 0) begin
            e = (q0.size() != 0) ? q0.pop_front() : 99999;
          end else begin
            e = (q1.size() != 0) ? q1.pop_front() : 99999;
          end
          chk($sformatf("%s dut%0d beat%0d", s.name, d, beats[d]), rdata[d], e);
          chk($sformatf("%s dut%0d last%0d", s.name, d, beats[d]), rlast[d], (beats[d] == NB - 1));
          beats[d]++;
          if (d == 0) last_hs = it;
        end
        stall[d] = rvalid[d] && !i_rready;
        pd[d] = rdata[d];
        pl[d] = rlast[d];
      end
      if (s.rst_at >= 0 && beats[0] == s.rst_at) begin
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          chk({s.name, " rst_rvalid"}, rvalid[d], 0);
          chk({s.name, " rst_busy"}, busy[d], 0);
        end
        i_valid = 1'b0;
        i_rready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) chk({s.name, " post_rst_busy"}, busy[d], 0);
        return;
      end
      if (dones[0] != 0 && dones[1] != 0) begin
        fin = 1'b1;
        break;
      end
      tick();
    end
    i_valid = 1'b0;
    i_rready = 1'b0;

    chk({s.name, " finished"}, fin, 1);
    for (int d = 0; d < 2; d++) begin
      chk({s.name, " beats"}, beats[d], NB);
      chk({s.name, " dones"}, dones[d], 1);
      chk({s.name, " ovf_end"}, ovf[d], s.exp_ovf);
    end
    if (s.chk_lat) begin
      chk({s.name, " first_latency"}, first_v, 2);
      chk({s.name, " gapless"}, last_hs - first_v, NB - 1);
    end
  endtask

  scen_t tbl[7];

  initial begin
    tbl[0] = '{"basic",        -18, 1'b0, 40, 100, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
    tbl[1] = '{"backpressure", -18, 1'b0, 20,  50, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    tbl[2] = '{"stray_idle",   -18, 1'b0, 30, 100, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1};
    tbl[3] = '{"stray_drain",  -18, 1'b0, 30,  70, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0};
    tbl[4] = '{"mid_start",    -18, 1'b0, 30, 100, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1};
    tbl[5] = '{"rst_drain",    -18, 1'b0, 10, 100, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0};
    tbl[6] = '{"random",         0, 1'b1,  0,  60, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0};

    rst_n = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_rready = 1'b0;
    i_y = '0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset rvalid", rvalid[d], 0);
      chk("reset rlast", rlast[d], 0);
      chk("reset rdata", rdata[d], 0);
      chk("reset busy", busy[d], 0);
      chk("reset done", done[d], 0);
      chk("reset ovf", ovf[d], 0);
    end
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) run_frame(tbl[k]);
    run_frame(tbl[0]);

    tick();
    for (int d = 0; d < 2; d++) chk("done_one_cycle", done[d], 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
